// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between instruction fetch and
// data access. One transaction at a time. Data normally wins a collision,
// but a streak counter caps consecutive data grants so a waiting fetch
// is never starved.
module mem_port_arbiter #(
  parameter int MAX_D_STREAK = 4,
  parameter int STREAK_W     = 4
) (
  input  logic        clk,
  input  logic        rst,
  // instruction fetch port
  input  logic        i_read,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_resp,
  // data port
  input  logic        d_read,
  input  logic        d_write,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_byte_enable,
  output logic [31:0] d_rdata,
  output logic        d_resp,
  // memory bus
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_byte_enable,
  input  logic [31:0] mem_rdata,
  input  logic        mem_resp,
  // debug / stall visibility
  output logic [1:0]  owner
);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    SERVE_I = 2'b01,
    SERVE_D = 2'b10
  } state_t;

  localparam logic [STREAK_W-1:0] MAX_STREAK = STREAK_W'(MAX_D_STREAK);

  state_t              state_reg;
  logic [STREAK_W-1:0] streak_reg;
  logic                mem_read_reg;
  logic                mem_write_reg;
  logic [31:0]         mem_addr_reg;
  logic [31:0]         mem_wdata_reg;
  logic [3:0]          mem_byte_enable_reg;

  logic d_req;
  logic grant_d;
  logic grant_i;

  // The bus is word addressed; the low address bits are intentionally dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{i_addr[1:0], d_addr[1:0]};

  // Arbitration decision, only acted upon in IDLE.
  always_comb begin
    d_req   = d_read | d_write;
    grant_d = d_req && (!i_read || (streak_reg < MAX_STREAK));
    grant_i = i_read && !grant_d;
  end

  // Transaction FSM: captures the winning request into the bus registers
  // and holds them until the memory completes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg           <= IDLE;
      streak_reg          <= '0;
      mem_read_reg        <= 1'b0;
      mem_write_reg       <= 1'b0;
      mem_addr_reg        <= '0;
      mem_wdata_reg       <= '0;
      mem_byte_enable_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (grant_d) begin
            state_reg           <= SERVE_D;
            // A store wins if both strobes are (illegally) raised together.
            mem_write_reg       <= d_write;
            mem_read_reg        <= ~d_write;
            mem_addr_reg        <= {d_addr[31:2], 2'b00};
            mem_wdata_reg       <= d_wdata;
            mem_byte_enable_reg <= d_byte_enable;
            if (!i_read) begin
              streak_reg <= '0;
            end else if (streak_reg != MAX_STREAK) begin
              streak_reg <= streak_reg + STREAK_W'(1);
            end
          end else if (grant_i) begin
            state_reg           <= SERVE_I;
            mem_read_reg        <= 1'b1;
            mem_write_reg       <= 1'b0;
            mem_addr_reg        <= {i_addr[31:2], 2'b00};
            mem_wdata_reg       <= '0;
            mem_byte_enable_reg <= 4'b1111;
            streak_reg          <= '0;
          end
        end
        SERVE_I, SERVE_D: begin
          if (mem_resp) begin
            state_reg     <= IDLE;
            mem_read_reg  <= 1'b0;
            mem_write_reg <= 1'b0;
          end
        end
        default: begin
          state_reg     <= IDLE;
          mem_read_reg  <= 1'b0;
          mem_write_reg <= 1'b0;
        end
      endcase
    end
  end

  // Completion is routed only to the current owner; a stray mem_resp in IDLE
  // produces nothing.
  always_comb begin
    i_resp  = (state_reg == SERVE_I) && mem_resp;
    d_resp  = (state_reg == SERVE_D) && mem_resp;
    i_rdata = mem_rdata;
    d_rdata = mem_rdata;
  end

  assign mem_read        = mem_read_reg;
  assign mem_write       = mem_write_reg;
  assign mem_addr        = mem_addr_reg;
  assign mem_wdata       = mem_wdata_reg;
  assign mem_byte_enable = mem_byte_enable_reg;
  assign owner           = state_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: reset, single fetch, collision,
// held outputs, stray response and the starvation guard.
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst;
  logic        i_read;
  logic [31:0] i_addr;
  logic [31:0] i_rdata;
  logic        i_resp;
  logic        d_read;
  logic        d_write;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_byte_enable;
  logic [31:0] d_rdata;
  logic        d_resp;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_byte_enable;
  logic [31:0] mem_rdata;
  logic        mem_resp;
  logic [1:0]  owner;

  int errors = 0;
  int checks = 0;

  mem_port_arbiter #(.MAX_D_STREAK(4), .STREAK_W(4)) dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_byte_enable(d_byte_enable), .d_rdata(d_rdata), .d_resp(d_resp),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_byte_enable(mem_byte_enable),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp), .owner(owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 ns later.
  task automatic next_cycle();
    @(negedge clk);
  endtask

  logic [1:0] grants [6];
  int         ngrants;

  initial begin
    rst = 1'b1; i_read = 1'b0; i_addr = '0; d_read = 1'b0; d_write = 1'b0;
    d_addr = '0; d_wdata = '0; d_byte_enable = '0; mem_rdata = '0; mem_resp = 1'b0;

    // ---- reset state
    next_cycle(); #1;
    check("rst_mem_read", 32'(mem_read), 32'h0);
    check("rst_mem_write", 32'(mem_write), 32'h0);
    check("rst_owner", 32'(owner), 32'h0);
    check("rst_mem_addr", mem_addr, 32'h0);
    rst = 1'b0;

    // ---- asynchronous reset mid-transaction
    next_cycle();
    i_read = 1'b1; i_addr = 32'h0000_0040;
    next_cycle(); #1;
    check("pre_rst_mem_read", 32'(mem_read), 32'h1);
    mem_resp = 1'b1;  // would complete the fetch if reset were ignored
    #2 rst = 1'b1;
    #1;
    check("async_rst_mem_read", 32'(mem_read), 32'h0);
    check("async_rst_owner", 32'(owner), 32'h0);
    check("async_rst_i_resp", 32'(i_resp), 32'h0);
    next_cycle();
    mem_resp = 1'b0; rst = 1'b0;
    #1;
    check("post_rst_idle_mem_read", 32'(mem_read), 32'h0);
    next_cycle(); #1;
    check("post_rst_grant_mem_read", 32'(mem_read), 32'h1);
    check("post_rst_grant_owner", 32'(owner), 32'h1);
    mem_resp = 1'b1; i_read = 1'b0;
    #1;
    check("post_rst_i_resp", 32'(i_resp), 32'h1);
    next_cycle();
    mem_resp = 1'b0;

    // ---- single fetch, memory answers three cycles after the strobe
    next_cycle();
    i_read = 1'b1; i_addr = 32'h0000_0060;
    next_cycle(); #1;
    check("fetch_mem_read", 32'(mem_read), 32'h1);
    check("fetch_mem_addr", mem_addr, 32'h0000_0060);
    check("fetch_mem_be", 32'(mem_byte_enable), 32'hF);
    check("fetch_owner", 32'(owner), 32'h1);
    for (int k = 0; k < 2; k++) begin
      next_cycle(); #1;
      check("fetch_wait_i_resp", 32'(i_resp), 32'h0);
    end
    next_cycle();
    mem_resp = 1'b1; mem_rdata = 32'h00A0_0093; i_read = 1'b0;
    #1;
    check("fetch_i_resp", 32'(i_resp), 32'h1);
    check("fetch_i_rdata", i_rdata, 32'h00A0_0093);
    check("fetch_d_resp", 32'(d_resp), 32'h0);
    next_cycle();
    mem_resp = 1'b0;
    #1;
    check("fetch_done_i_resp", 32'(i_resp), 32'h0);
    check("fetch_done_mem_read", 32'(mem_read), 32'h0);
    check("fetch_done_owner", 32'(owner), 32'h0);

    // ---- collision: data first, then instruction; held outputs in SERVE_D
    i_read = 1'b1; i_addr = 32'h0000_0080;
    d_write = 1'b1; d_addr = 32'h0000_1003; d_byte_enable = 4'b0110; d_wdata = 32'hDEAD_BEEF;
    next_cycle(); #1;
    check("coll_mem_write", 32'(mem_write), 32'h1);
    check("coll_mem_read", 32'(mem_read), 32'h0);
    check("coll_mem_addr", mem_addr, 32'h0000_1000);
    check("coll_mem_be", 32'(mem_byte_enable), 32'h6);
    check("coll_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    check("coll_owner", 32'(owner), 32'h2);
    d_write = 1'b0; d_addr = 32'h0000_2000; d_wdata = 32'h1234_5678; d_byte_enable = 4'b0001;
    next_cycle(); #1;
    check("held_mem_addr", mem_addr, 32'h0000_1000);
    check("held_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    check("held_mem_be", 32'(mem_byte_enable), 32'h6);
    check("held_mem_write", 32'(mem_write), 32'h1);
    mem_resp = 1'b1;
    #1;
    check("coll_d_resp", 32'(d_resp), 32'h1);
    check("coll_i_resp_quiet", 32'(i_resp), 32'h0);
    next_cycle();
    mem_resp = 1'b0;
    #1;
    check("coll_gap_mem_write", 32'(mem_write), 32'h0);
    check("coll_gap_mem_read", 32'(mem_read), 32'h0);
    check("coll_gap_owner", 32'(owner), 32'h0);
    next_cycle(); #1;
    check("coll_i_grant_mem_read", 32'(mem_read), 32'h1);
    check("coll_i_grant_addr", mem_addr, 32'h0000_0080);
    check("coll_i_grant_wdata", mem_wdata, 32'h0);
    mem_resp = 1'b1; i_read = 1'b0;
    #1;
    check("coll_i_resp", 32'(i_resp), 32'h1);
    check("coll_d_resp_quiet", 32'(d_resp), 32'h0);
    next_cycle();
    mem_resp = 1'b0;

    // ---- stray response in IDLE
    next_cycle();
    mem_resp = 1'b1;
    #1;
    check("stray_i_resp", 32'(i_resp), 32'h0);
    check("stray_d_resp", 32'(d_resp), 32'h0);
    next_cycle();
    mem_resp = 1'b0;
    #1;
    check("stray_owner", 32'(owner), 32'h0);
    check("stray_mem_read", 32'(mem_read), 32'h0);

    // ---- starvation guard: both requests held, 1-cycle memory
    i_read = 1'b1; i_addr = 32'h0000_0300;
    d_read = 1'b1; d_addr = 32'h0000_0200;
    ngrants = 0;
    for (int c = 0; c < 30 && ngrants < 6; c++) begin
      next_cycle(); #1;
      mem_resp = mem_read | mem_write;
      if (mem_resp) begin
        grants[ngrants] = owner;
        ngrants++;
      end
    end
    next_cycle();
    mem_resp = 1'b0; i_read = 1'b0; d_read = 1'b0;
    check("starve_grant_count", 32'(ngrants), 32'd6);
    for (int g = 0; g < 6; g++) begin
      check($sformatf("starve_grant_%0d", g), 32'(grants[g]), (g == 4) ? 32'h1 : 32'h2);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
